sync_gen: RTL and testbench

SYNC_GEN -- requirements
Module: sync_gen

---
 rtl/sync_gen.sv | 87 ++++++++
 tb/tb_sync_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sync_gen.sv
// 640x480@60 style raster timing: free-running cycle counter, half-rate pixel enable, pixel/line counters and sync/blank decodes.
// Decodes are combinational on the registered counters (zero added latency); no backpressure, the raster free-runs.
module sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  score,
  output logic [23:0] cnt,
  output logic        pix_en,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        in_disp_area,
  output logic [3:0]  tens,
  output logic [3:0]  ones
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic lineEnd;
  logic frameEnd;
  logic [11:0] bcdShift;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

  assign pix_en   = cnt[0];
  assign lineEnd  = (hcount == H_LAST);
  assign frameEnd = (vcount == V_LAST);

  // Line and frame counters only move on pixel-enable edges; vcount steps as hcount wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (lineEnd) begin
        hcount <= '0;
        vcount <= frameEnd ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  assign hsync        = !((hcount >= HS_START) && (hcount < HS_END));
  assign vsync        = !((vcount >= VS_START) && (vcount < VS_END));
  assign in_disp_area = (hcount < H_VIS_END) && (vcount < V_VIS_END);

  // Double-dabble; the hundreds nibble is formed but never driven out.
  always_comb begin
    bcdShift = '0;
    for (int i = 6; i >= 0; i--) begin
      if (bcdShift[3:0] >= 4'd5) bcdShift[3:0] = bcdShift[3:0] + 4'd3;
      if (bcdShift[7:4] >= 4'd5) bcdShift[7:4] = bcdShift[7:4] + 4'd3;
      bcdShift = {bcdShift[10:0], score[i]};
    end
  end

  assign ones = bcdShift[3:0];
  assign tens = bcdShift[7:4];

endmodule

// File: tb/tb_sync_gen.sv
// Directed bench: default-timing instance for reset/horizontal/line/BCD checks, shrunk-timing instance for frame/vsync checks.
module tb_sync_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        resetS = 1'b0;
  logic [6:0]  score = 7'd0;
  logic [23:0] cnt;
  logic        pix_en;
  logic [9:0]  hcount, vcount;
  logic        hsync, vsync, in_disp_area;
  logic [3:0]  tens, ones;

  logic [23:0] cntS;
  logic        pixEnS;
  logic [9:0]  hcountS, vcountS;
  logic        hsyncS, vsyncS, inDispS;
  logic [3:0]  tensS, onesS;

  int nAssert = 0;
  int nFail = 0;
  int edges = 0;

  always #5 clock = ~clock;

  sync_gen dut (
    .clock(clock), .reset_n(reset_n), .score(score), .cnt(cnt), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .in_disp_area(in_disp_area), .tens(tens), .ones(ones)
  );

  // Line = 17 pixels, frame = 13 lines, vsync on lines 8..9.
  sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dutS (
    .clock(clock), .reset_n(resetS), .score(7'd0), .cnt(cntS), .pix_en(pixEnS),
    .hcount(hcountS), .vcount(vcountS), .hsync(hsyncS), .vsync(vsyncS),
    .in_disp_area(inDispS), .tens(tensS), .ones(onesS)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the given number of rising edges since the last reset release, then sample 1 ns later.
  task automatic stepTo(input int target);
    while (edges < target) begin
      @(posedge clock);
      edges++;
    end
    #1;
  endtask

  task automatic checkBcd(input logic [6:0] val, input logic [3:0] expT, input logic [3:0] expO);
    score = val;
    #1;
    check($sformatf("tens(%0d)", val), 32'(tens), 32'(expT));
    check($sformatf("ones(%0d)", val), 32'(ones), 32'(expO));
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst cnt", 32'(cnt), 0);
    check("rst hcount", 32'(hcount), 0);
    check("rst vcount", 32'(vcount), 0);
    check("rst pix_en", 32'(pix_en), 0);
    check("rst hsync", 32'(hsync), 1);
    check("rst vsync", 32'(vsync), 1);
    check("rst in_disp", 32'(in_disp_area), 1);

    @(negedge clock);
    reset_n = 1'b1;
    edges = 0;
    stepTo(1);
    check("edge1 cnt", 32'(cnt), 1);
    check("edge1 pix_en", 32'(pix_en), 1);
    check("edge1 hcount", 32'(hcount), 0);
    stepTo(2);
    check("edge2 hcount", 32'(hcount), 1);

    stepTo(1279);
    check("1279 hcount", 32'(hcount), 639);
    check("1279 in_disp", 32'(in_disp_area), 1);
    stepTo(1280);
    check("1280 hcount", 32'(hcount), 640);
    check("1280 in_disp", 32'(in_disp_area), 0);
    stepTo(1310);
    check("1310 hsync", 32'(hsync), 1);
    stepTo(1312);
    check("1312 hcount", 32'(hcount), 656);
    check("1312 hsync", 32'(hsync), 0);
    stepTo(1502);
    check("1502 hsync", 32'(hsync), 0);
    stepTo(1504);
    check("1504 hcount", 32'(hcount), 752);
    check("1504 hsync", 32'(hsync), 1);
    stepTo(1598);
    check("1598 hcount", 32'(hcount), 799);
    check("1598 vcount", 32'(vcount), 0);
    stepTo(1600);
    check("1600 hcount", 32'(hcount), 0);
    check("1600 vcount", 32'(vcount), 1);
    check("1600 cnt", 32'(cnt), 1600);
    check("1600 in_disp", 32'(in_disp_area), 1);

    stepTo(1701);
    check("pre-arst vcount", 32'(vcount), 1);
    check("pre-arst hcount", 32'(hcount), 50);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst cnt", 32'(cnt), 0);
    check("arst hcount", 32'(hcount), 0);
    check("arst vcount", 32'(vcount), 0);
    @(negedge clock);
    reset_n = 1'b1;
    edges = 0;
    stepTo(1);
    check("rerelease cnt", 32'(cnt), 1);
    check("rerelease hcount", 32'(hcount), 0);

    checkBcd(7'd0, 4'd0, 4'd0);
    checkBcd(7'd9, 4'd0, 4'd9);
    checkBcd(7'd10, 4'd1, 4'd0);
    checkBcd(7'd57, 4'd5, 4'd7);
    checkBcd(7'd99, 4'd9, 4'd9);
    checkBcd(7'd127, 4'd2, 4'd7);
    checkBcd(7'd100, 4'd0, 4'd0);
    reset_n = 1'b0;
    checkBcd(7'd45, 4'd4, 4'd5);

    @(negedge clock);
    resetS = 1'b1;
    edges = 0;
    stepTo(270);
    check("S 270 vcount", 32'(vcountS), 7);
    check("S 270 vsync", 32'(vsyncS), 1);
    stepTo(272);
    check("S 272 vcount", 32'(vcountS), 8);
    check("S 272 hcount", 32'(hcountS), 0);
    check("S 272 vsync", 32'(vsyncS), 0);
    check("S 272 hsync", 32'(hsyncS), 1);
    stepTo(292);
    check("S 292 hcount", 32'(hcountS), 10);
    check("S 292 hsync", 32'(hsyncS), 0);
    stepTo(338);
    check("S 338 vcount", 32'(vcountS), 9);
    check("S 338 vsync", 32'(vsyncS), 0);
    stepTo(340);
    check("S 340 vcount", 32'(vcountS), 10);
    check("S 340 vsync", 32'(vsyncS), 1);
    stepTo(441);
    check("S 441 hcount", 32'(hcountS), 16);
    check("S 441 vcount", 32'(vcountS), 12);
    stepTo(442);
    check("S frame hcount", 32'(hcountS), 0);
    check("S frame vcount", 32'(vcountS), 0);
    check("S frame cnt", 32'(cntS), 442);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
